// File: rtl/vt_encoder.sv
// vt_encoder: serial Varshamov-Tenengolts encoder, one codeword position per cycle then a check-bit fix cycle.
// Optional macro VT_SELFCHECK_EN adds a VERIFY re-scan and the syn_err output.
module vt_encoder #(
    parameter int n = 10,
    parameter int a = 0,
    localparam int M = $clog2(n + 1),
    localparam int K = n - M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [K-1:0] msg,
    output logic [n-1:0] codeword,
    output logic         busy,
    output logic         done
`ifdef VT_SELFCHECK_EN
    ,
    output logic         syn_err
`endif
);
    if (n < 3 || n > 255 || a < 0 || a > n) begin : g_bad_param
        $error("vt_encoder: n must be 3..255 and a must be 0..n");
    end

    localparam logic [M-1:0] NL = M'(n);
    localparam logic [M:0]   AL = (M + 1)'(a);
    localparam logic [M+1:0] N1 = (M + 2)'(n + 1);
    localparam logic [M+1:0] A2 = (M + 2)'(a);

`ifdef VT_SELFCHECK_EN
    typedef enum logic [2:0] {IDLE, SCAN, FIX, VERIFY, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SCAN, FIX, DONE} state_t;
`endif

    state_t         state;
    logic [M-1:0]   i;
    logic [M:0]     acc;
    logic [K-1:0]   sh;
    logic           is_chk;
    logic           xb;
    logic           add_bit;
    logic [M+1:0]   sum;
    logic [M+1:0]   acc_w;
    logic [M:0]     acc_add;
    logic [M:0]     acc_nxt;
    logic [M-1:0]   d;

    // Position class, bit to accumulate and the modular add/fix arithmetic
    always_comb begin
        is_chk  = (i & (i - 1'b1)) == '0;
        xb      = is_chk ? 1'b0 : sh[0];
        add_bit = (state == SCAN) ? xb : codeword[i - 1'b1];
        acc_w   = {1'b0, acc};
        sum     = acc_w + (M + 2)'(i);
        acc_add = (M + 1)'((sum >= N1) ? sum - N1 : sum);
        acc_nxt = add_bit ? acc_add : acc;
        d       = M'((A2 >= acc_w) ? A2 - acc_w : A2 + N1 - acc_w);
    end

    // Encoder FSM: accept, scan positions, fix check bits, (verify), signal done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            codeword <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            i        <= '0;
            acc      <= '0;
            sh       <= '0;
`ifdef VT_SELFCHECK_EN
            syn_err  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh       <= msg;
                        codeword <= '0;
                        acc      <= '0;
                        i        <= M'(1);
                        busy     <= 1'b1;
                        state    <= SCAN;
`ifdef VT_SELFCHECK_EN
                        syn_err  <= 1'b0;
`endif
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    codeword[i - 1'b1] <= xb;
                    if (!is_chk) sh <= sh >> 1;
                    acc <= acc_nxt;
                    if (i == NL) state <= FIX;
                    else i <= i + 1'b1;
                end
                FIX: begin
                    for (int j = 0; j < M; j++) codeword[(1 << j) - 1] <= d[j];
`ifdef VT_SELFCHECK_EN
                    i     <= M'(1);
                    acc   <= '0;
                    state <= VERIFY;
                end
                VERIFY: begin
                    acc <= acc_nxt;
                    if (i == NL) begin
                        syn_err <= acc_nxt != AL;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        i <= i + 1'b1;
                    end
`else
                    done  <= 1'b1;
                    state <= DONE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vt_encoder.sv
// tb_vt_encoder: directed and random checks of vt_encoder (n=10) with a=0 and a=5 instances.
module tb_vt_encoder;
`ifdef VT_SELFCHECK_EN
    localparam int LAT = 22;
    logic se0, se5;
`else
    localparam int LAT = 12;
`endif
    logic       clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start5 = 1'b0;
    logic [5:0] msg = '0;
    logic [9:0] cw0, cw5;
    logic       busy0, busy5, done0, done5;
    int         vectors = 0, miscompares = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    vt_encoder #(.n(10), .a(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .msg(msg),
        .codeword(cw0), .busy(busy0), .done(done0)
`ifdef VT_SELFCHECK_EN
        , .syn_err(se0)
`endif
    );

    vt_encoder #(.n(10), .a(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .msg(msg),
        .codeword(cw5), .busy(busy5), .done(done5)
`ifdef VT_SELFCHECK_EN
        , .syn_err(se5)
`endif
    );

    function automatic logic [9:0] vt_model(input logic [5:0] m, input int av);
        logic [9:0] cw;
        int k, s, dd;
        cw = '0;
        k = 0;
        s = 0;
        for (int p = 1; p <= 10; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8) begin
                cw[p-1] = m[k];
                if (m[k]) s += p;
                k++;
            end
        end
        dd = ((av - s) % 11 + 11) % 11;
        cw[0] = dd[0];
        cw[1] = dd[1];
        cw[3] = dd[2];
        cw[7] = dd[3];
        return cw;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit sel, input logic [5:0] m, input logic [9:0] exp_cw, input string tag);
        int c;
        msg = m;
        if (sel) start5 = 1'b1;
        else start0 = 1'b1;
        sb.push_back(exp_cw);
        @(negedge clk);
        start0 = 1'b0;
        start5 = 1'b0;
        c = 1;
        while (!(sel ? done5 : done0) && c < 3 * LAT) begin
            @(negedge clk);
            c++;
        end
        chk({tag, " latency"}, c, LAT);
        chk({tag, " codeword"}, sel ? cw5 : cw0, sb.pop_front());
`ifdef VT_SELFCHECK_EN
        chk({tag, " syn_err"}, sel ? se5 : se0, 0);
`endif
        @(negedge clk);
        chk({tag, " busy_after"}, sel ? busy5 : busy0, 0);
    endtask

    initial begin
        int nd;
        logic [5:0] m;
        repeat (2) @(negedge clk);
        chk("reset cw", cw0, 0);
        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        chk("reset cw a5", cw5, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 6'h00, 10'h000, "a0 m00");
        run(0, 6'h01, 10'h084, "a0 m01");
        run(0, 6'h3F, 10'h37C, "a0 m3f");
        run(1, 6'h00, 10'h009, "a5 m00");
        repeat (20) begin
            m = 6'($urandom_range(0, 63));
            run(0, m, vt_model(m, 0), "a0 rand");
            m = 6'($urandom_range(0, 63));
            run(1, m, vt_model(m, 5), "a5 rand");
        end

        // reset in the middle of an encode
        msg = 6'h3F;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst cw", cw0, 0);
        chk("midrst busy", busy0, 0);
        chk("midrst done", done0, 0);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge clk);
            if (done0) nd++;
        end
        chk("midrst no done", nd, 0);

        // start pulsed while busy is ignored
        msg = 6'h01;
        start0 = 1'b1;
        sb.push_back(10'h084);
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        msg = 6'h3F;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        msg = 6'h00;
        nd = 0;
        for (int k = 0; k < 2 * LAT + 5; k++) begin
            @(negedge clk);
            if (done0) begin
                nd++;
                chk("busy start cw", cw0, sb.size() > 0 ? sb.pop_front() : 10'h3FF);
            end
        end
        chk("busy start done count", nd, 1);

        // start held high for three back-to-back encodes
        msg = 6'h01;
        start0 = 1'b1;
        sb.push_back(10'h084);
        sb.push_back(10'h37C);
        sb.push_back(10'h000);
        nd = 0;
        for (int k = 1; k <= 3 * LAT + 2; k++) begin
            @(negedge clk);
            if (k == 1) msg = 6'h3F;
            if (k == LAT + 1) msg = 6'h00;
            if (k == 2 * LAT + 1) start0 = 1'b0;
            if (done0) begin
                nd++;
                chk("held done cycle", k, nd * LAT);
                chk("held cw", cw0, sb.size() > 0 ? sb.pop_front() : 10'h3FF);
            end
        end
        chk("held done count", nd, 3);
        chk("held idle", busy0, 0);

`ifdef VT_SELFCHECK_EN
        // corrupt the accumulator during VERIFY: self-check must flag it
        begin
            logic [4:0] v;
            msg = 6'h15;
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            repeat (13) @(negedge clk);
            v = dut0.acc;
            force dut0.acc = v ^ 5'd1;
            @(negedge clk);
            release dut0.acc;
            nd = 0;
            for (int k = 0; k < LAT; k++) begin
                @(negedge clk);
                if (done0) begin
                    nd++;
                    chk("forced syn_err", se0, 1);
                end
            end
            chk("forced done count", nd, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
